// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, ACK check, one data byte, ACK/NACK, STOP.
// SCL and the SDA pull-down are registered and decoded from the next state, so the bus never glitches.
module i2c_master_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [6:0] Addr,
  input  logic       RW,
  input  logic [7:0] Data_IN,
  output logic       SCL,
  inout  wire        SDA,
  output logic       Busy,
  output logic       Done,
  output logic       Ack_Err,
  output logic [7:0] Data_OUT
);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAddrAck, StWrite, StWack, StRead, StRnack, StStop
  } state_t;

  localparam logic [7:0] DivMax = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       rw_q, rw_d;
  logic       sda_low_q, sda_low_d, scl_d;
  logic       busy_d, done_d, ack_err_d;
  logic [7:0] data_out_d;
  logic       tick, slot_end, sample, sda_in;

  assign SDA      = sda_low_q ? 1'b0 : 1'bz;
  // Anything other than a solid 0 (released, unknown) reads as the pull-up level.
  assign sda_in   = (SDA !== 1'b0);
  assign tick     = (div_q == DivMax);
  assign slot_end = tick && (qtr_q == 2'd3);
  assign sample   = (qtr_q == 2'd2) && (div_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    wbyte_d    = wbyte_q;
    rw_d       = rw_q;
    busy_d     = Busy;
    done_d     = 1'b0;
    ack_err_d  = Ack_Err;
    data_out_d = Data_OUT;

    if (state_q == StIdle) begin
      // The Done cycle is still part of the finished transaction; no command is taken then.
      if (Start && !Done) begin
        state_d   = StStart;
        sh_d      = {Addr, RW};
        rw_d      = RW;
        wbyte_d   = Data_IN;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
        div_d     = 8'd0;
        qtr_d     = 2'd0;
        bit_d     = 3'd0;
      end
    end else begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      if (tick) qtr_d = qtr_q + 2'd1;

      if (sample) begin
        case (state_q)
          StAddrAck, StWack: if (sda_in) ack_err_d = 1'b1;
          StRead: begin
            sh_d = {sh_q[6:0], sda_in};
            if (bit_q == 3'd7) data_out_d = {sh_q[6:0], sda_in};
          end
          default: ;
        endcase
      end

      if (slot_end) begin
        case (state_q)
          StStart: state_d = StAddr;
          StAddr, StWrite: begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == StAddr) ? StAddrAck : StWack;
          end
          StAddrAck: begin
            if (Ack_Err) begin
              state_d = StStop;
            end else if (rw_q) begin
              state_d = StRead;
            end else begin
              state_d = StWrite;
              sh_d    = wbyte_q;
            end
          end
          StRead: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StRnack;
          end
          StWack, StRnack: state_d = StStop;
          StStop: begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Bus levels for the cycle being entered.
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      StIdle: ;
      StStart: begin
        scl_d     = ~qtr_d[1];
        sda_low_d = (qtr_d != 2'd0);
      end
      StAddr, StWrite: begin
        scl_d     = qtr_d[1];
        sda_low_d = ~sh_d[7];
      end
      StStop: begin
        scl_d     = qtr_d[1];
        sda_low_d = (qtr_d != 2'd3);
      end
      default: scl_d = qtr_d[1];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      sh_q      <= 8'd0;
      wbyte_q   <= 8'd0;
      rw_q      <= 1'b0;
      sda_low_q <= 1'b0;
      SCL       <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Ack_Err   <= 1'b0;
      Data_OUT  <= 8'h00;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wbyte_q   <= wbyte_d;
      rw_q      <= rw_d;
      sda_low_q <= sda_low_d;
      SCL       <= scl_d;
      Busy      <= busy_d;
      Done      <= done_d;
      Ack_Err   <= ack_err_d;
      Data_OUT  <= data_out_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: two instances (DIV=4, DIV=1) on pulled-up buses, a behavioural
// slave/monitor, and a transaction-level model of latency, bit stream, Ack_Err and Data_OUT.
module tb_i2c_master_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Start = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] Addr = 7'h00;
  logic       RW = 1'b0;
  logic [7:0] Data_IN = 8'h00;

  logic       scl4, scl1, busy4, busy1, done4, done1, err4, err1;
  logic [7:0] dout4, dout1;
  wire        sda4, sda1;
  logic       slave_low = 1'b0;

  logic       scl_m, sda_m, busy_m, done_m, err_m;
  logic [7:0] dout_m;

  int checks = 0;
  int errors = 0;

  pullup pu4 (sda4);
  pullup pu1 (sda1);
  assign sda4 = (!sel && slave_low) ? 1'b0 : 1'bz;
  assign sda1 = (sel && slave_low) ? 1'b0 : 1'bz;

  assign scl_m  = sel ? scl1 : scl4;
  assign sda_m  = sel ? sda1 : sda4;
  assign busy_m = sel ? busy1 : busy4;
  assign done_m = sel ? done1 : done4;
  assign err_m  = sel ? err1 : err4;
  assign dout_m = sel ? dout1 : dout4;

  always #5 CLK = ~CLK;

  i2c_master_ctrl #(.DIV(4)) dut4 (
    .CLK(CLK), .RST(RST), .Start(Start && !sel), .Addr(Addr), .RW(RW), .Data_IN(Data_IN),
    .SCL(scl4), .SDA(sda4), .Busy(busy4), .Done(done4), .Ack_Err(err4), .Data_OUT(dout4)
  );

  i2c_master_ctrl #(.DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .Start(Start && sel), .Addr(Addr), .RW(RW), .Data_IN(Data_IN),
    .SCL(scl1), .SDA(sda1), .Busy(busy1), .Done(done1), .Ack_Err(err1), .Data_OUT(dout1)
  );

  // Slave configuration and model state
  logic [6:0]  slave_addr = 7'h19;
  logic        slave_present = 1'b1;
  logic        data_ack = 1'b1;
  logic [7:0]  rbyte = 8'h00;
  int unsigned cur_div = 4;
  logic [7:0]  exp_dout = 8'h00;

  // Monitor / slave state (written only by the monitor process)
  logic scl_p = 1'b1, sda_p = 1'b1, in_txn = 1'b0, addr_acked = 1'b0, mrw = 1'b0;
  logic have_rise = 1'b0;
  int   cnt = 0, stops = 0, hi_changes = 0, cyc = 0, last_rise = 0, pmin = 0, pmax = 0;
  logic bits[$];

  function automatic logic addr_match();
    logic [6:0] a;
    for (int i = 0; i < 7; i++) a[6-i] = bits[i];
    return slave_present && (a == slave_addr);
  endfunction

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    scl_p <= scl_m;
    sda_p <= sda_m;
    if (RST) begin
      in_txn    <= 1'b0;
      slave_low <= 1'b0;
      cnt       <= 0;
    end else begin
      if (scl_p && scl_m && (sda_p !== sda_m)) hi_changes <= hi_changes + 1;
      if (scl_p && scl_m && sda_p && !sda_m) begin
        in_txn    <= 1'b1;
        cnt       <= 0;
        bits.delete();
        slave_low <= 1'b0;
        have_rise <= 1'b0;
        pmin      <= 1 << 20;
        pmax      <= 0;
      end else if (scl_p && scl_m && !sda_p && sda_m) begin
        if (in_txn) stops <= stops + 1;
        in_txn    <= 1'b0;
        slave_low <= 1'b0;
      end else if (in_txn) begin
        if (!scl_p && scl_m) begin
          bits.push_back(sda_m);
          if (have_rise) begin
            if (cyc - last_rise < pmin) pmin <= cyc - last_rise;
            if (cyc - last_rise > pmax) pmax <= cyc - last_rise;
          end
          last_rise <= cyc;
          have_rise <= 1'b1;
        end
        if (scl_p && !scl_m) begin
          cnt <= cnt + 1;
          if (cnt == 8) begin
            addr_acked <= addr_match();
            mrw        <= bits[7];
            slave_low  <= addr_match();
          end else if (cnt >= 9 && cnt <= 16) begin
            slave_low <= addr_acked && mrw && !rbyte[16-cnt];
          end else if (cnt == 17) begin
            slave_low <= addr_acked && !mrw && data_ack;
          end else begin
            slave_low <= 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
    Addr = a; RW = r; Data_IN = d; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    // Scramble the command inputs so only the latched copy can produce the right stream.
    Addr = ~a; RW = ~r; Data_IN = ~d;
    checks++;
    if (busy_m !== 1'b1 || err_m !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b ack_err=%b, required busy=1 ack_err=0", busy_m, err_m);
    end
  endtask

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d, input bit spam,
                         input string tag);
    logic        acked, exp_err;
    logic        exp_bits[$];
    int          lat, n, stops0, hi0;
    logic [31:0] got_v, exp_v;
    acked   = slave_present && (a == slave_addr);
    lat     = (acked ? 80 : 44) * int'(cur_div);
    exp_err = !acked || (!r && !data_ack);
    for (int i = 6; i >= 0; i--) exp_bits.push_back(a[i]);
    exp_bits.push_back(r);
    exp_bits.push_back(!acked);
    if (acked) begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(r ? rbyte[i] : d[i]);
      exp_bits.push_back(r ? 1'b1 : !data_ack);
      if (r) exp_dout = rbyte;
    end
    exp_bits.push_back(1'b0);  // STOP slot clock pulse, SDA still low
    stops0 = stops;
    hi0    = hi_changes;
    issue(a, r, d);
    n = 1;
    while (n <= lat + 50) begin
      if (spam && (n == 10 || n == 200)) begin
        Start = 1'b1; Addr = 7'($urandom); Data_IN = 8'($urandom);
      end
      @(posedge CLK); #1;
      Start = 1'b0;
      if (done_m) break;
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles, required %0d", tag, n, lat);
    end
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, required 0", tag, busy_m);
    end
    checks++;
    if (err_m !== exp_err) begin
      errors++;
      $display("FAIL %s ack_err: got %b, required %b", tag, err_m, exp_err);
    end
    checks++;
    if (dout_m !== exp_dout) begin
      errors++;
      $display("FAIL %s data_out: got %h, required %h", tag, dout_m, exp_dout);
    end
    got_v = '0;
    exp_v = '0;
    foreach (bits[i]) got_v = {got_v[30:0], bits[i]};
    foreach (exp_bits[i]) exp_v = {exp_v[30:0], exp_bits[i]};
    checks++;
    if (bits.size() != exp_bits.size() || got_v !== exp_v) begin
      errors++;
      $display("FAIL %s sda_stream: got %0d bits %b, required %0d bits %b", tag, bits.size(),
               got_v, exp_bits.size(), exp_v);
    end
    checks++;
    if (stops - stops0 != 1 || hi_changes - hi0 != 2) begin
      errors++;
      $display("FAIL %s start_stop: got stops=%0d high_sda_edges=%0d, required 1 and 2", tag,
               stops - stops0, hi_changes - hi0);
    end
    checks++;
    if (pmin != 4 * int'(cur_div) || pmax != 4 * int'(cur_div)) begin
      errors++;
      $display("FAIL %s scl_period: got min=%0d max=%0d, required %0d", tag, pmin, pmax,
               4 * cur_div);
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(posedge CLK); #1;
    checks++;
    if (done_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b, required 0 0", tag, done_m, busy_m);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({scl_m, sda_m, busy_m, done_m, err_m} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_bus: got scl,sda,busy,done,err=%b, required 11000",
               {scl_m, sda_m, busy_m, done_m, err_m});
    end
    checks++;
    if (dout_m !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h, required 00", dout_m);
    end
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_write();
    slave_present = 1'b1; data_ack = 1'b1;
    run_txn(7'h19, 1'b0, 8'hA5, 1'b0, "write_a5");
    check_idle_after("write_a5");
  endtask

  task automatic test_nack();
    slave_present = 1'b0;
    run_txn(7'h33, 1'b0, 8'h5A, 1'b0, "addr_nack");
    check_idle_after("addr_nack");
    slave_present = 1'b1;
  endtask

  task automatic test_read();
    rbyte = 8'h3C;
    run_txn(7'h19, 1'b1, 8'h00, 1'b0, "read_3c");
    check_idle_after("read_3c");
  endtask

  task automatic test_back_to_back();
    data_ack = 1'b1;
    run_txn(7'h19, 1'b0, 8'hC3, 1'b1, "spam_start");
    // Start during the Done cycle must be dropped.
    Start = 1'b1; Addr = 7'h19; RW = 1'b1; Data_IN = 8'h11;
    @(posedge CLK); #1;
    Start = 1'b0;
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b, required 0 0", busy_m, done_m);
    end
    run_txn(7'h19, 1'b0, 8'h96, 1'b0, "start_after_done");
    check_idle_after("start_after_done");
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic       r;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      a             = ($urandom_range(0, 1) == 0) ? 7'h19 : 7'($urandom_range(0, 127));
      r             = 1'($urandom_range(0, 1));
      d             = 8'($urandom);
      slave_present = ($urandom_range(0, 3) != 0);
      data_ack      = 1'($urandom_range(0, 1));
      rbyte         = 8'($urandom);
      run_txn(a, r, d, 1'b0, $sformatf("rand%0d", i));
      check_idle_after($sformatf("rand%0d", i));
    end
    slave_present = 1'b1;
    data_ack      = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int dones;
    issue(7'h19, 1'b0, 8'h69);
    repeat (213) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    exp_dout = 8'h00;
    checks++;
    if ({scl_m, sda_m, busy_m, done_m, err_m} !== 5'b11000 || dout_m !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got scl,sda,busy,done,err=%b dout=%h, required 11000 00",
               {scl_m, sda_m, busy_m, done_m, err_m}, dout_m);
    end
    @(posedge CLK); #1;
    RST   = 1'b0;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      if (done_m || busy_m) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d busy/done cycles, required 0", dones);
    end
    run_txn(7'h19, 1'b0, 8'h3E, 1'b0, "after_reset");
    check_idle_after("after_reset");
  endtask

  task automatic test_div1();
    sel      = 1'b1;
    cur_div  = 1;
    exp_dout = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    run_txn(7'h19, 1'b0, 8'hFF, 1'b0, "div1_ff");
    check_idle_after("div1_ff");
    rbyte = 8'($urandom);
    run_txn(7'h19, 1'b1, 8'h00, 1'b0, "div1_read");
    check_idle_after("div1_read");
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_read();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master transaction controller; sequences the two-wire bus (SCL, open-drain SDA) that drives the team's I2C Slave.
- Takes a one-cycle command (7-bit address, R/W, write byte) from system logic.
- Generates START, address byte, ACK check, one data byte (write or read), and STOP.
- Reports completion, ACK error and read data.

Parameters:
- DIV, 4: CLK cycles per SCL quarter-period. SCL period = 4*DIV CLK cycles; legal range 1..255.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  command strobe; sampled only when in IDLE.
- Addr  input  7  slave address, latched on accepted Start.
- RW  input  1  transfer direction, latched on accepted Start; 0 = write, 1 = read.
- Data_IN  input  8  write byte, latched on accepted Start.
- SCL  output  1  bus clock, push-pull.
- SDA  inout  1  bus data, open-drain: drives 0 or Z only, never 1.
- Busy  output  1  high while a transaction is in progress.
- Done  output  1  one-cycle pulse at transaction end.
- Ack_Err  output  1  high if the slave NACKed; held until the next accepted Start.
- Data_OUT  output  8  last byte read; holds its value otherwise.

Behaviour:
- Reset values (asynchronous on RST=1):
  - SCL=1; SDA released (Z).
  - Busy=0, Done=0, Ack_Err=0, Data_OUT=8'h00.
  - State=IDLE; quarter counter and bit counter cleared.
- Reset mid-transaction: bus released immediately; no STOP generated; the command is discarded.
- Timing base: a divider counts 0..DIV-1; each wrap advances the quarter index q (0..3). One bit slot = 4 quarters = 4*DIV CLK cycles.
  - q0, q1: SCL=0.
  - q2, q3: SCL=1.
  - SDA may change only at q0 entry.
  - SDA is sampled on the first CLK of q2.
- States:
  - IDLE: SCL=1, SDA=Z. On Start=1, latch Addr, RW, Data_IN, clear Ack_Err, go START; Busy=1 from the next cycle.
  - START (1 slot): SDA pulled 0 at q1 while SCL is still 1 (SCL held 1 for q0..q1 of this slot only), then SCL=0 for q2..q3. Go ADDR.
  - ADDR (8 slots): shift out {Addr,RW}, MSB first.
  - ADDR_ACK (1 slot): release SDA and sample it.
    - 1 → Ack_Err=1, go STOP.
    - 0 → go WRITE if RW=0, else READ.
  - WRITE (8 slots): shift out Data_IN, MSB first. Go WACK.
  - WACK (1 slot): release SDA and sample; 1 → Ack_Err=1. Go STOP.
  - READ (8 slots): SDA released; shift sampled bits in, MSB first. Data_OUT updated on the cycle the 8th bit is sampled.
  - RNACK (1 slot): master leaves SDA released (NACK). Go STOP.
  - STOP (1 slot): SDA=0 during q0..q1; SCL=1 at q2; SDA released at q3 (SDA rises while SCL is high). Go IDLE.
- On entering IDLE from STOP: Done=1 for exactly one cycle and Busy=0 in that same cycle.
- Transaction length:
  - ACKed transfer = 20 slots. Done asserts 80*DIV CLK cycles after the Start-accept cycle.
  - Address NACK = 11 slots, i.e. 44*DIV cycles.
- Start while Busy=1 (including the Done cycle): ignored, no queuing.
- Start in the cycle after Done: accepted normally.
- A sampled SDA value of Z or X is treated as 1 (NACK); the bench must model the pull-up.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary. No clock stretching; no arbitration.

Test Plan:
- DIV=4. Start with Addr=7'h19, RW=0, Data_IN=8'hA5; slave model ACKs both bytes.
  - SDA bit stream after START = 0011_0010 (ACK) 1010_0101 (ACK).
  - Done pulses 320 cycles after accept; Ack_Err=0.
- Write to Addr=7'h33 with no slave driving ACK (pull-up only):
  - Ack_Err=1 after the address slot; STOP follows immediately.
  - Done at 176 cycles; no data bits driven.
- Read from Addr=7'h19; slave returns 8'h3C after ACK:
  - Data_OUT=8'h3C when Done pulses.
  - Master leaves SDA released in the 9th data slot.
- Start re-asserted at cycles 10 and 200 of an active transaction:
  - Latched Addr and Data_IN unchanged; exactly one Done.
  - Start in the cycle after Done begins a new transaction.
- RST pulsed mid-WRITE (bit 3):
  - SCL=1, SDA=Z and Busy=0 within the same cycle; no Done pulse.
  - A subsequent write completes correctly.
- DIV=1 write of 8'hFF:
  - SCL period = 4 cycles; Done at 80 cycles.
  - SDA changes only while SCL=0, except during START and STOP.
